column_buffer_ctrl: RTL and testbench

- Ping-pong controller for one simple dual-port RAM of depth 2*COLS, split into two banks of COLS column entries.
- The raycaster fills the back bank one column per handshake. The scanline renderer reads random columns from the front bank.
- Banks swap only at vsync, and only when the back bank is complete, so the display never shows a partial frame.
- Single clock domain: the RAM's wclk and rclk are both driven from clk.

---
 rtl/column_buffer_ctrl.sv | 82 ++++++++
 tb/tb_column_buffer_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/column_buffer_ctrl.sv
// column_buffer_ctrl: ping-pong column buffer, fills the back bank and serves reads from the front bank
module column_buffer_ctrl #(
    parameter int SIZE = 32,
    parameter int COLS = 320,
    localparam int AW = $clog2(2 * COLS),
    localparam int CW = $clog2(COLS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            vsync,
    input  logic            wr_valid,
    input  logic [SIZE-1:0] wr_data,
    output logic            wr_ready,
    output logic            fill_done,
    input  logic            rd_req,
    input  logic [CW-1:0]   rd_col,
    output logic            rd_valid,
    output logic [SIZE-1:0] rd_data,
    output logic            front_valid,
    output logic [15:0]     swap_count,
    output logic [15:0]     miss_count,
    output logic [AW-1:0]   ram_waddr,
    output logic [SIZE-1:0] ram_wdata,
    output logic            ram_we,
    output logic [AW-1:0]   ram_raddr,
    input  logic [SIZE-1:0] ram_rdata
);
    typedef enum logic {FILL, DONE} state_t;
    state_t          state, state_nxt;
    logic            front_sel;
    logic [CW-1:0]   col_cnt;
    logic            accept, last, swap, rd_ok, rd_in_range;
    logic [AW-1:0]   front_base, back_base;

    assign front_base  = front_sel ? AW'(COLS) : '0;
    assign back_base   = front_sel ? '0 : AW'(COLS);
    assign rd_in_range = front_valid && (int'(rd_col) < COLS);
    assign ram_raddr   = rd_in_range ? front_base + AW'(rd_col) : front_base;
    assign ram_waddr   = back_base + AW'(col_cnt);
    assign ram_wdata   = wr_data;
    assign rd_data     = (rd_valid && rd_ok) ? ram_rdata : '0;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= FILL;
        else        state <= state_nxt;
    end

    // Next state and handshake outputs; a vsync swaps only once the back bank is complete
    always_comb begin
        wr_ready  = state == FILL;
        fill_done = state == DONE;
        accept    = wr_ready && wr_valid;
        ram_we    = accept;
        last      = accept && (col_cnt == CW'(COLS - 1));
        swap      = fill_done && vsync;
        state_nxt = swap ? FILL : last ? DONE : state;
    end

    // Fill counter, bank select, frame counters and read pipeline
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            front_sel   <= 1'b0;
            col_cnt     <= '0;
            rd_valid    <= 1'b0;
            rd_ok       <= 1'b0;
            front_valid <= 1'b0;
            swap_count  <= '0;
            miss_count  <= '0;
        end else begin
            if (accept) col_cnt <= last ? '0 : col_cnt + 1'b1;
            if (swap) begin
                front_sel   <= ~front_sel;
                front_valid <= 1'b1;
                swap_count  <= swap_count + 16'd1;
            end
            if (vsync && !fill_done) miss_count <= miss_count + 16'd1;
            rd_valid <= rd_req;
            rd_ok    <= rd_req && rd_in_range;
        end
    end
endmodule

// File: tb/tb_column_buffer_ctrl.sv
// tb_column_buffer_ctrl: directed checks of fill, swap, miss, read clamping and reset
module tb_column_buffer_ctrl;
    localparam int SIZE = 32;
    localparam int COLS = 320;

    logic            clk = 0;
    logic            rst_n, vsync, wr_valid, rd_req;
    logic [SIZE-1:0] wr_data;
    logic [8:0]      rd_col;
    logic            wr_ready, fill_done, rd_valid, front_valid, ram_we;
    logic [SIZE-1:0] rd_data, ram_wdata, ram_rdata;
    logic [15:0]     swap_count, miss_count;
    logic [9:0]      ram_waddr, ram_raddr;
    logic [SIZE-1:0] mem [0:2*COLS-1];
    int checks = 0;
    int errors = 0;

    column_buffer_ctrl #(.SIZE(SIZE), .COLS(COLS)) dut (
        .clk(clk), .rst_n(rst_n), .vsync(vsync), .wr_valid(wr_valid), .wr_data(wr_data),
        .wr_ready(wr_ready), .fill_done(fill_done), .rd_req(rd_req), .rd_col(rd_col),
        .rd_valid(rd_valid), .rd_data(rd_data), .front_valid(front_valid),
        .swap_count(swap_count), .miss_count(miss_count), .ram_waddr(ram_waddr),
        .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // Simple dual-port RAM with registered read
    always @(posedge clk) begin
        if (ram_we) mem[ram_waddr] <= ram_wdata;
        ram_rdata <= mem[ram_raddr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_vsync();
        vsync = 1;
        tick();
        vsync = 0;
    endtask

    task automatic write_cols(input int base, input int start, input int n, input int off);
        for (int i = 0; i < n; i++) begin
            wr_valid = 1;
            wr_data  = off + start + i;
            #1;
            checks++;
            if (ram_we !== 1'b1 || wr_ready !== 1'b1 || int'(ram_waddr) != base + start + i
                || ram_wdata !== wr_data) begin
                errors++;
                $display("FAIL write col %0d: we=%b ready=%b waddr=%0d wdata=%0d, want we=1 ready=1 waddr=%0d wdata=%0d",
                         start + i, ram_we, wr_ready, ram_waddr, ram_wdata, base + start + i, wr_data);
            end
            @(posedge clk);
            #1;
        end
        wr_valid = 0;
    endtask

    task automatic read_col(input int col, input int exp_addr, input int exp_data);
        rd_req = 1;
        rd_col = 9'(col);
        #1;
        checks++;
        if (int'(ram_raddr) != exp_addr) begin
            errors++;
            $display("FAIL raddr col %0d: got %0d want %0d", col, ram_raddr, exp_addr);
        end
        @(posedge clk);
        #1;
        rd_req = 0;
        checks++;
        if (rd_valid !== 1'b1 || int'(rd_data) != exp_data) begin
            errors++;
            $display("FAIL rdata col %0d: valid=%b data=%0d want valid=1 data=%0d", col, rd_valid, rd_data, exp_data);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (wr_ready !== 1'b1 || fill_done !== 1'b0 || rd_valid !== 1'b0 || rd_data !== '0
            || front_valid !== 1'b0 || swap_count !== 16'd0 || miss_count !== 16'd0 || ram_we !== 1'b0) begin
            errors++;
            $display("FAIL %s: ready=%b done=%b rv=%b rd=%0d fv=%b swaps=%0d misses=%0d we=%b, want 1 0 0 0 0 0 0 0",
                     tag, wr_ready, fill_done, rd_valid, rd_data, front_valid, swap_count, miss_count, ram_we);
        end
    endtask

    task automatic test_reset();
        rst_n = 0;
        tick();
        tick();
        check_reset_outputs("reset");
        rst_n = 1;
    endtask

    task automatic test_fill_swap();
        write_cols(COLS, 0, COLS, 0);
        checks++;
        if (fill_done !== 1'b1 || wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL fill_done: done=%b ready=%b want 1 0", fill_done, wr_ready);
        end
        wr_valid = 1;
        #1;
        checks++;
        if (ram_we !== 1'b0) begin
            errors++;
            $display("FAIL we in DONE: got %b want 0", ram_we);
        end
        wr_valid = 0;
        pulse_vsync();
        checks++;
        if (swap_count !== 16'd1 || front_valid !== 1'b1 || fill_done !== 1'b0 || wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL first swap: swaps=%0d fv=%b done=%b ready=%b want 1 1 0 1",
                     swap_count, front_valid, fill_done, wr_ready);
        end
    endtask

    task automatic test_read();
        read_col(5, 325, 5);
        write_cols(0, 0, COLS, 1000);
        pulse_vsync();
        checks++;
        if (swap_count !== 16'd2) begin
            errors++;
            $display("FAIL second swap: swaps=%0d want 2", swap_count);
        end
        read_col(5, 5, 1005);
    endtask

    task automatic test_miss();
        write_cols(COLS, 0, 100, 2000);
        pulse_vsync();
        checks++;
        if (miss_count !== 16'd1 || swap_count !== 16'd2 || fill_done !== 1'b0) begin
            errors++;
            $display("FAIL miss: misses=%0d swaps=%0d done=%b want 1 2 0", miss_count, swap_count, fill_done);
        end
        write_cols(COLS, 100, 220, 2000);
        pulse_vsync();
        checks++;
        if (swap_count !== 16'd3 || miss_count !== 16'd1) begin
            errors++;
            $display("FAIL swap after miss: swaps=%0d misses=%0d want 3 1", swap_count, miss_count);
        end
        read_col(319, 639, 2319);
    endtask

    task automatic test_coincident();
        write_cols(0, 0, COLS - 1, 3000);
        wr_valid = 1;
        wr_data  = 3319;
        vsync    = 1;
        tick();
        wr_valid = 0;
        vsync    = 0;
        checks++;
        if (miss_count !== 16'd2 || swap_count !== 16'd3 || fill_done !== 1'b1) begin
            errors++;
            $display("FAIL coincident: misses=%0d swaps=%0d done=%b want 2 3 1", miss_count, swap_count, fill_done);
        end
        pulse_vsync();
        checks++;
        if (swap_count !== 16'd4 || fill_done !== 1'b0) begin
            errors++;
            $display("FAIL swap after coincident: swaps=%0d done=%b want 4 0", swap_count, fill_done);
        end
        read_col(319, 319, 3319);
    endtask

    task automatic test_oob();
        read_col(400, 0, 0);
        rst_n = 0;
        tick();
        rst_n = 1;
        read_col(3, 0, 0);
    endtask

    task automatic test_midreset_pipeline();
        write_cols(COLS, 0, 150, 5000);
        rst_n = 0;
        tick();
        check_reset_outputs("mid-frame reset");
        rst_n = 1;
        write_cols(COLS, 0, COLS, 4000);
        pulse_vsync();
        for (int c = 0; c < 10; c++) begin
            rd_req = 1;
            rd_col = 9'(c);
            #1;
            checks++;
            if (int'(ram_raddr) != 320 + c) begin
                errors++;
                $display("FAIL pipe raddr %0d: got %0d want %0d", c, ram_raddr, 320 + c);
            end
            @(posedge clk);
            #1;
            checks++;
            if (rd_valid !== 1'b1 || int'(rd_data) != 4000 + c) begin
                errors++;
                $display("FAIL pipe data %0d: valid=%b data=%0d want 1 %0d", c, rd_valid, rd_data, 4000 + c);
            end
        end
        rd_req = 0;
        tick();
        checks++;
        if (rd_valid !== 1'b0 || rd_data !== '0) begin
            errors++;
            $display("FAIL pipe idle: valid=%b data=%0d want 0 0", rd_valid, rd_data);
        end
    endtask

    initial begin
        rst_n = 0; vsync = 0; wr_valid = 0; wr_data = '0; rd_req = 0; rd_col = '0;
        test_reset();
        test_fill_swap();
        test_read();
        test_miss();
        test_coincident();
        test_oob();
        test_midreset_pipeline();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
